rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- Reorder-buffer storage and in-order retire unit; the consumer side of the renamer's ROB-ID protocol.
- Allocates ROB IDs at decode and captures execution results and exceptions at writeback.
- Serves ROB-typed source operands to issue.
- Retires the head entry through commit_e_/com_rob_id. These signals feed the rename map invalidate port and the architectural register file write.

Parameters:
- ROB_DEPTH, `RobDepth (16): number of ROB entries; must be a power of 2.
- ROB, $clog2(ROB_DEPTH): ROB ID width.
- DATA, 64: result data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_  in  1  active-low pipeline flush
- alloc_e_  in  1  active-low allocate request from decode
- alloc_rd  in  $bits(RegFile_t)  destination register of the allocated instruction
- alloc_rob_id  out  ROB  ID granted this cycle (current tail)
- rob_full  out  1  no free entry
- rob_empty  out  1  no valid entry
- wb_e_  in  1  active-low writeback strobe
- wb_rob_id  in  ROB  writeback target entry
- wb_data  in  DATA  result
- wb_exp  in  1  exception flag
- rob_raddr  in  2*ROB  operand read IDs {rs2,rs1}
- rob_rdata  out  2*DATA  operand data {rs2,rs1}
- rob_ready  out  2  per-port: result available
- commit_e_  out  1  active-low commit strobe
- com_rob_id  out  ROB  committing entry ID
- com_rd  out  $bits(RegFile_t)  architectural destination
- com_data  out  DATA  committed result
- com_we_  out  1  active-low architectural register file write
- com_exp  out  1  committing entry carries an exception

Behaviour:
- **State**
  - head and tail pointers, each ROB bits wide; they wrap modulo ROB_DEPTH.
  - count register, ROB+1 bits.
  - Per entry: valid, done, exp, rd, data.
- **Reset** (takes effect at the next edge): head=tail=count=0; all valid/done/exp=0.
  - Resulting outputs: commit_e_=1, com_we_=1, com_exp=0, rob_full=0, rob_empty=1, alloc_rob_id=0, rob_ready=0.
  - Reset mid-operation discards all entries with no commit.
- **Status**
  - rob_full = (count==ROB_DEPTH).
  - rob_empty = (count==0).
  - Both are combinational from registers.
- **Allocate**
  - Accepted when !alloc_e_ && !rob_full && flush_.
  - On acceptance: entry[tail] gets valid=1, done=0, exp=0, rd=alloc_rd; tail advances by 1.
  - alloc_rob_id=tail is combinational.
  - A request while full is dropped silently; decode must stall on rob_full.
- **Writeback**
  - When !wb_e_ && entry[wb_rob_id].valid: done=1, data=wb_data, exp=wb_exp, visible the next cycle.
  - Writeback to an invalid entry is ignored.
- **Commit** (combinational from registers, one per cycle)
  - commit_e_=0 iff entry[head].valid && entry[head].done && flush_.
  - com_rob_id=head; com_rd, com_data, com_exp come from entry[head].
  - com_we_=0 iff commit && !com_exp && com_rd.regtype is GPR or FPR. A GPR destination must not be x0.
  - On commit: entry[head].valid=0 and head advances.
  - Latency: writeback at cycle t leads to commit at t+1 at the earliest.
- **Exception**
  - An entry with exp commits with com_exp=1 and no register write.
  - The upper level asserts flush_ afterwards; this block does not self-flush.
- **Count**
  - count += accepted alloc, count -= commit; both in the same cycle leaves count unchanged.
  - Allocate-when-full is judged on the pre-edge count, so a simultaneous commit does not admit an allocate that cycle.
- **Flush** (flush_=0)
  - Same cycle: commit_e_ forced high, allocate blocked.
  - At the edge: head=tail=count=0 and all valid=0.
  - Writeback in the flush cycle is discarded.
- **Read ports** (combinational, per port i)
  - rob_ready[i] = valid && done of entry[raddr_i], or same-cycle bypass.
  - Bypass: !wb_e_ && wb_rob_id==raddr_i && entry valid gives rob_ready=1 and rob_rdata=wb_data.
  - Otherwise rob_rdata=entry data.
- **Assertions**
  - Never commit when empty.
  - count never exceeds ROB_DEPTH.
  - tail-head == count modulo ROB_DEPTH, except when full.

Test Plan:
1. **In-order retire:** after reset, allocate 3 entries (GPR x5, x6, x7) → IDs 0, 1, 2. Write back ID1, then ID0 one cycle later → commit ID0 (com_we_=0, com_rd=x5) the next cycle, then ID1 the cycle after. No commit of ID2 until its writeback.
2. **Full and wrap:** allocate 16 with no writeback → rob_full=1, and a 17th alloc is dropped (count stays 16). Write back ID0 → it commits, rob_full drops, and the next allocation receives ID0.
3. **Flush:** with 5 valid entries and ID0 done, drive flush_=0 → commit_e_=1 that cycle. Next cycle rob_empty=1 and alloc_rob_id=0, and a late writeback to ID2 has no effect.
4. **Exception:** head ID0 written back with wb_exp=1, data 0x1234 → commit_e_=0, com_exp=1, com_we_=1, head advances to 1.
5. **Read bypass:** ID3 valid, not done; rob_raddr rs1=3 with same-cycle writeback ID3 data 0xDEAD → rob_ready[0]=1, rob_rdata[0]=0xDEAD. Next cycle the data is the same, now served from storage.
6. **Reset and x0:** hold reset for 1 cycle with 8 entries, 4 done → no commit, empty after the edge. Then allocate x0 as destination, write it back → commit_e_=0 with com_we_=1.

Source files
------------

// File: rtl/rob_commit_if.sv
// Bus between decode, writeback, issue and retire on one side and the reorder buffer on the other.
// Carries allocation, result capture, operand reads and the in-order commit stream.
`ifndef RobDepth
`define RobDepth 16
`endif

interface rob_commit_if #(
    parameter int ROB_DEPTH = `RobDepth,
    parameter int DATA      = 64
);
    localparam int ROB = $clog2(ROB_DEPTH);

    // regtype: 0 = GPR, 1 = FPR, 2 = CSR, 3 = none; only GPR (not x0) and FPR reach the RF.
    typedef struct packed {
        logic [1:0] regtype;
        logic [4:0] num;
    } RegFile_t;

    // Strobes flush_, alloc_e_, wb_e_, commit_e_ and com_we_ are active-low and act at the
    // edge that samples them. rob_full is the only back-pressure: an allocate issued while
    // it is high is dropped, so decode must hold off. The commit stream cannot be stalled.
    logic            flush_;
    logic            alloc_e_;
    RegFile_t        alloc_rd;
    logic [ROB-1:0]  alloc_rob_id;
    logic            rob_full;
    logic            rob_empty;
    logic            wb_e_;
    logic [ROB-1:0]  wb_rob_id;
    logic [DATA-1:0] wb_data;
    logic            wb_exp;
    logic [2*ROB-1:0]  rob_raddr;
    logic [2*DATA-1:0] rob_rdata;
    logic [1:0]      rob_ready;
    logic            commit_e_;
    logic [ROB-1:0]  com_rob_id;
    RegFile_t        com_rd;
    logic [DATA-1:0] com_data;
    logic            com_we_;
    logic            com_exp;

    modport master (
        output flush_, alloc_e_, alloc_rd, wb_e_, wb_rob_id, wb_data, wb_exp, rob_raddr,
        input  alloc_rob_id, rob_full, rob_empty, rob_rdata, rob_ready,
               commit_e_, com_rob_id, com_rd, com_data, com_we_, com_exp
    );

    modport slave (
        input  flush_, alloc_e_, alloc_rd, wb_e_, wb_rob_id, wb_data, wb_exp, rob_raddr,
        output alloc_rob_id, rob_full, rob_empty, rob_rdata, rob_ready,
               commit_e_, com_rob_id, com_rd, com_data, com_we_, com_exp
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates IDs at decode, captures results at writeback, serves ROB operands
// to issue and retires the head entry in program order, one per cycle.
`ifndef RobDepth
`define RobDepth 16
`endif

module rob_commit #(
    parameter int ROB_DEPTH = `RobDepth,
    parameter int DATA      = 64
) (
    input  logic       clk,
    input  logic       reset,
    rob_commit_if.slave bus
);
    localparam int ROB = $clog2(ROB_DEPTH);
    localparam logic [1:0] REG_GPR = 2'd0;
    localparam logic [1:0] REG_FPR = 2'd1;

    // Same layout as RegFile_t in rob_commit_if.
    typedef struct packed {
        logic [1:0] regtype;
        logic [4:0] num;
    } rd_t;

    logic [ROB-1:0]       head;
    logic [ROB-1:0]       tail;
    logic [ROB:0]         count;
    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] done;
    logic [ROB_DEPTH-1:0] exp;
    rd_t                  rd_mem   [ROB_DEPTH];
    logic [DATA-1:0]      data_mem [ROB_DEPTH];

    logic           full;
    logic           empty;
    logic           alloc_acc;
    logic           wb_hit;
    logic           commit;
    logic           head_writes_rf;
    rd_t            head_rd;
    logic [ROB-1:0] raddr [2];
    logic [ROB-1:0] occ_span;

    assign full  = (count == (ROB+1)'(ROB_DEPTH));
    assign empty = (count == '0);

    // Reset and flush both suppress allocate and commit in the cycle they are asserted.
    assign alloc_acc = !reset && bus.flush_ && !bus.alloc_e_ && !full;
    assign wb_hit    = !reset && bus.flush_ && !bus.wb_e_ && valid[bus.wb_rob_id];
    assign commit    = !reset && bus.flush_ && valid[head] && done[head];

    assign head_rd        = rd_mem[head];
    assign head_writes_rf = ((head_rd.regtype == REG_GPR) && (head_rd.num != 5'd0)) ||
                            (head_rd.regtype == REG_FPR);

    always_ff @(posedge clk) begin
        if (reset || !bus.flush_) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            exp   <= '0;
        end else begin
            if (alloc_acc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                exp[tail]   <= 1'b0;
                tail        <= tail + ROB'(1);
            end
            if (wb_hit) begin
                done[bus.wb_rob_id] <= 1'b1;
                exp[bus.wb_rob_id]  <= bus.wb_exp;
            end
            // A same-cycle writeback to the retiring entry cannot revive it: valid clear wins.
            if (commit) begin
                valid[head] <= 1'b0;
                head        <= head + ROB'(1);
            end
            count <= count + (ROB+1)'(alloc_acc) - (ROB+1)'(commit);
        end
    end

    // Payload storage carries no reset; valid/done gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            rd_mem[tail] <= bus.alloc_rd;
        end
        if (wb_hit) begin
            data_mem[bus.wb_rob_id] <= bus.wb_data;
        end
    end

    assign bus.alloc_rob_id = tail;
    assign bus.rob_full     = full;
    assign bus.rob_empty    = empty;

    assign bus.commit_e_  = !commit;
    assign bus.com_rob_id = head;
    assign bus.com_rd     = head_rd;
    assign bus.com_data   = data_mem[head];
    assign bus.com_exp    = commit && exp[head];
    assign bus.com_we_    = !(commit && !exp[head] && head_writes_rf);

    assign raddr[0] = bus.rob_raddr[ROB-1:0];
    assign raddr[1] = bus.rob_raddr[2*ROB-1:ROB];

    // Port 0 is rs1 (low half), port 1 is rs2; a matching writeback is forwarded same cycle.
    always_comb begin
        bus.rob_ready = '0;
        bus.rob_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            if (!bus.wb_e_ && (bus.wb_rob_id == raddr[i]) && valid[raddr[i]]) begin
                bus.rob_ready[i]             = 1'b1;
                bus.rob_rdata[i*DATA +: DATA] = bus.wb_data;
            end else begin
                bus.rob_ready[i]             = valid[raddr[i]] && done[raddr[i]];
                bus.rob_rdata[i*DATA +: DATA] = data_mem[raddr[i]];
            end
        end
    end

    assign occ_span = tail - head;

    a_no_commit_empty: assert property (@(posedge clk) disable iff (reset) !(commit && empty));
    a_count_bound:     assert property (@(posedge clk) disable iff (reset)
                                        count <= (ROB+1)'(ROB_DEPTH));
    a_ptr_count:       assert property (@(posedge clk) disable iff (reset)
                                        full || (occ_span == count[ROB-1:0]));
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic against a queue-based ROB model;
// commits are predicted into exp_q and checked by an independent negedge monitor.
module tb_rob_commit;
    localparam int DEPTH = 16;
    localparam int DATA  = 64;
    localparam int ROB   = 4;
    localparam int CW    = ROB + 7 + DATA + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rob_commit_if #(.ROB_DEPTH(DEPTH), .DATA(DATA)) bus ();
    rob_commit    #(.ROB_DEPTH(DEPTH), .DATA(DATA)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Model: program-order list of live instructions.
    typedef struct {
        int          id;
        logic [6:0]  rd;
        bit          done;
        bit          exp;
        logic [63:0] data;
    } ent_t;

    ent_t           mq[$];
    int             next_id;
    logic [CW-1:0]  exp_q[$];
    logic [CW-1:0]  rec;
    int             cand[$];
    int             total;
    int             bad;
    bit             mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int find(input int id);
        for (int k = 0; k < mq.size(); k++) if (mq[k].id == id) return k;
        return -1;
    endfunction

    // RF write happens for a non-exception GPR (not x0) or FPR destination.
    function automatic logic exp_we_n(input ent_t e);
        logic writes;
        writes = ((e.rd[6:5] == 2'd0) && (e.rd[4:0] != 5'd0)) || (e.rd[6:5] == 2'd1);
        return !(!e.exp && writes);
    endfunction

    task automatic tick();
        bit          c;
        bit          acc;
        int          idx;
        logic [ROB-1:0] ra;
        bit          rdy [2];
        logic [63:0] rdat [2];
        int          n_pre;
        int          id_pre;
        c = !reset && bus.flush_ && (mq.size() > 0) && mq[0].done;
        if (c) exp_q.push_back({4'(mq[0].id), mq[0].rd, mq[0].data, mq[0].exp, exp_we_n(mq[0])});
        for (int p = 0; p < 2; p++) begin
            ra = bus.rob_raddr[p*ROB +: ROB];
            rdy[p] = 0;
            rdat[p] = '0;
            idx = find(int'(ra));
            if (idx >= 0) begin
                if (!bus.wb_e_ && bus.wb_rob_id == ra) begin
                    rdy[p] = 1; rdat[p] = bus.wb_data;
                end else if (mq[idx].done) begin
                    rdy[p] = 1; rdat[p] = mq[idx].data;
                end
            end
        end
        n_pre  = mq.size();
        id_pre = next_id;
        @(negedge clk);
        check("rob_full", 64'(bus.rob_full), 64'(n_pre == DEPTH));
        check("rob_empty", 64'(bus.rob_empty), 64'(n_pre == 0));
        check("alloc_rob_id", 64'(bus.alloc_rob_id), 64'(id_pre));
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rob_ready%0d", p), 64'(bus.rob_ready[p]), 64'(rdy[p]));
            if (rdy[p]) check($sformatf("rob_rdata%0d", p), bus.rob_rdata[p*DATA +: DATA], rdat[p]);
        end
        @(posedge clk);
        if (reset || !bus.flush_) begin
            mq.delete();
            next_id = 0;
        end else begin
            acc = !bus.alloc_e_ && (mq.size() < DEPTH);
            if (!bus.wb_e_) begin
                idx = find(int'(bus.wb_rob_id));
                if (idx >= 0) begin
                    mq[idx].done = 1; mq[idx].data = bus.wb_data; mq[idx].exp = bus.wb_exp;
                end
            end
            if (c) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{next_id, bus.alloc_rd, 0, 0, 64'h0});
                next_id = (next_id + 1) % DEPTH;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.commit_e_ === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_commit: got id %0d want no commit", bus.com_rob_id);
                end else begin
                    rec = exp_q.pop_front();
                    check("com_rob_id", 64'(bus.com_rob_id), 64'(rec[CW-1 -: ROB]));
                    check("com_rd", 64'(bus.com_rd), 64'(rec[CW-ROB-1 -: 7]));
                    check("com_data", bus.com_data, rec[DATA+1:2]);
                    check("com_exp", 64'(bus.com_exp), 64'(rec[1]));
                    check("com_we_", 64'(bus.com_we_), 64'(rec[0]));
                end
            end else if (exp_q.size() != 0) begin
                rec = exp_q.pop_front();
                total++; bad++;
                $display("FAIL missing_commit: got none want id %0d", rec[CW-1 -: ROB]);
            end
        end
    end

    task automatic idle();
        bus.flush_ = 1'b1; bus.alloc_e_ = 1'b1; bus.alloc_rd = '0;
        bus.wb_e_ = 1'b1; bus.wb_rob_id = '0; bus.wb_data = '0; bus.wb_exp = 1'b0;
    endtask

    task automatic do_alloc(input logic [6:0] rd);
        idle(); bus.alloc_e_ = 1'b0; bus.alloc_rd = rd; tick(); idle();
    endtask

    task automatic do_wb(input int id, input logic [63:0] d, input logic e);
        idle(); bus.wb_e_ = 1'b0; bus.wb_rob_id = 4'(id); bus.wb_data = d; bus.wb_exp = e;
        tick(); idle();
    endtask

    task automatic do_idle(input int n);
        idle(); repeat (n) tick();
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; tick(); reset = 1'b0;
    endtask

    initial begin
        int guard;
        total = 0; bad = 0; mon_en = 0; next_id = 0;
        idle(); bus.rob_raddr = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        // Reset state with reset still held: outputs come from the cleared registers.
        do_reset();
        check("reset_commit_e_", 64'(bus.commit_e_), 64'd1);
        check("reset_com_we_", 64'(bus.com_we_), 64'd1);

        // In-order retire.
        do_alloc({2'd0, 5'd5}); do_alloc({2'd0, 5'd6}); do_alloc({2'd0, 5'd7});
        do_wb(1, 64'h11, 0); do_wb(0, 64'h10, 0); do_idle(4);
        do_wb(2, 64'h12, 0); do_idle(2);

        // Full and wrap, with a dropped 17th allocate.
        do_reset();
        for (int i = 0; i < 17; i++) do_alloc({2'd1, 5'(i)});
        do_wb(0, 64'hAA, 0); do_idle(1);
        do_alloc({2'd0, 5'd9}); do_idle(1);

        // Flush with a writeback in the flush cycle and one after it.
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc({2'd0, 5'(i + 1)});
        do_wb(0, 64'h55, 0);
        idle(); bus.flush_ = 1'b0; bus.wb_e_ = 1'b0; bus.wb_rob_id = 4'd2; bus.wb_data = 64'h77;
        tick();
        do_wb(2, 64'h78, 0); do_idle(2);

        // Exception at the head, then the upper level flushes.
        do_reset();
        do_alloc({2'd0, 5'd5}); do_alloc({2'd0, 5'd6});
        do_wb(0, 64'h1234, 1); do_idle(1);
        idle(); bus.flush_ = 1'b0; tick(); idle();

        // Read bypass, then the same read served from storage.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc({2'd0, 5'(i + 10)});
        bus.rob_raddr = {4'd0, 4'd3};
        do_wb(3, 64'hDEAD, 0); do_idle(1);
        bus.rob_raddr = '0;

        // Reset with a done head discards without commit; then an x0 destination.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc({2'd0, 5'(i + 1)});
        do_wb(1, 64'h1, 0); do_wb(2, 64'h2, 0); do_wb(3, 64'h3, 0); do_wb(0, 64'h0F, 0);
        do_reset();
        do_alloc({2'd0, 5'd0}); do_wb(0, 64'h99, 0); do_idle(2);
        do_alloc({2'd2, 5'd3}); do_wb(1, 64'h98, 0); do_idle(2);

        // Random traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset         = ($urandom_range(0, 299) == 0);
            bus.flush_    = !($urandom_range(0, 79) == 0);
            bus.alloc_e_  = ($urandom_range(0, 2) == 0);
            bus.alloc_rd  = 7'($urandom);
            cand.delete();
            foreach (mq[k]) if (!mq[k].done) cand.push_back(mq[k].id);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
                bus.wb_e_     = 1'b0;
                bus.wb_rob_id = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end else begin
                bus.wb_e_     = 1'($urandom_range(0, 1));
                bus.wb_rob_id = 4'($urandom);
            end
            bus.wb_data   = {$urandom, $urandom};
            bus.wb_exp    = ($urandom_range(0, 7) == 0);
            bus.rob_raddr = 8'($urandom);
            if ($urandom_range(0, 1) != 0) bus.rob_raddr[ROB-1:0] = bus.wb_rob_id;
            tick();
        end
        reset = 1'b0;

        // Drain everything still in flight.
        guard = 0;
        idle();
        while (mq.size() > 0 && guard < 200) begin
            idle();
            cand.delete();
            foreach (mq[k]) if (!mq[k].done) cand.push_back(mq[k].id);
            if (cand.size() > 0) begin
                bus.wb_e_ = 1'b0; bus.wb_rob_id = 4'(cand[0]); bus.wb_data = {$urandom, $urandom};
            end
            tick();
            guard++;
        end
        idle();
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d live entries want 0", mq.size());
        end
        do_idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_commits: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
